egg_timer_ctrl: RTL and testbench
=================================

EGG_TIMER_CTRL -- requirements
Module: egg_timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 100000000, CLK cycles per countdown second; legal range >= 4.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SCLR  input  1  reset, asynchronous, active-high.
REQ-004 btn_start  input  1  start/resume/acknowledge request; single-cycle pulse, debounced upstream.
REQ-005 btn_stop  input  1  pause/cancel/acknowledge request; single-cycle pulse.
REQ-006 btn_sec_inc  input  1  add one second while idle; single-cycle pulse.
REQ-007 btn_min_inc  input  1  add one minute while idle; single-cycle pulse.
REQ-008 sec_q  input  6  current value of the external seconds counter (0..59).
REQ-009 min_q  input  6  current value of the external minutes counter (0..59).
REQ-010 sec_en  output  1  enable to the seconds counter; one-cycle pulse.
REQ-011 sec_up  output  1  direction to the seconds counter; 1 = up, 0 = down.
REQ-012 min_en  output  1  enable to the minutes counter; one-cycle pulse.
REQ-013 min_up  output  1  direction to the minutes counter; 1 = up, 0 = down.
REQ-014 cnt_clr  output  1  clear to both counters; one-cycle pulse.
REQ-015 state  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM.
REQ-016 alarm  output  1  high exactly while state is ALARM.

Function
REQ-017 All outputs are registered; each pulse appears in the cycle after the triggering input or tick.
REQ-018 The tick counter counts 0..TICK_DIV-1 only while in RUN, holds its value in PAUSE, and is cleared in IDLE and ALARM.
REQ-019 tick fires on the cycle the tick counter equals TICK_DIV-1; the counter then wraps to 0.
REQ-020 IDLE: btn_sec_inc -> sec_en=1, sec_up=1; btn_min_inc -> min_en=1, min_up=1; both together -> both pulses; counter wrap 59->0 is the counter's job, with no carry into minutes.
REQ-021 IDLE: btn_start with sec_q=0 and min_q=0 is ignored; otherwise the next state is RUN with the tick counter at 0.
REQ-022 IDLE: btn_stop -> cnt_clr pulse, state stays IDLE.
REQ-023 RUN, on tick: sec_en=1, sec_up=0; if sec_q=0 then min_en=1, min_up=0 (borrow, seconds wrap 0->59 in the counter).
REQ-024 RUN, on tick with min_q=0 and sec_q=1: decrement as in REQ-023 and go to ALARM on the same edge.
REQ-025 RUN with sec_q=0 and min_q=0 and no tick in progress: go to ALARM on the next edge without issuing enables.
REQ-026 RUN: btn_stop -> PAUSE, with no decrement that cycle even if tick coincides; the tick counter holds at TICK_DIV-1 and the tick fires on resume.
REQ-027 RUN: btn_start, btn_sec_inc and btn_min_inc are ignored.
REQ-028 PAUSE: btn_start -> RUN; btn_stop -> IDLE with a cnt_clr pulse; increment buttons are ignored.
REQ-029 ALARM: btn_start or btn_stop -> IDLE; counters are left untouched (already 0).
REQ-030 When btn_start and btn_stop arrive in the same cycle, btn_stop has priority in every state.
REQ-031 sec_up and min_up hold their last driven value when the matching enable is low.

Reset
REQ-032 On SCLR: state=IDLE, tick counter=0, sec_en=min_en=cnt_clr=alarm=0, sec_up=min_up=0; this takes effect immediately, including mid-RUN or mid-pulse.
REQ-033 After SCLR deasserts, the first valid transition is on the next rising CLK edge.

Verification (TICK_DIV=4)
REQ-034 Reset, IDLE, sec_q=0, min_q=0, btn_start -> state stays 0, no enables.
REQ-035 IDLE, btn_sec_inc and btn_min_inc in the same cycle -> next cycle sec_en=min_en=1, sec_up=min_up=1, each for one cycle.
REQ-036 Counters modelled at min=1, sec=0, btn_start -> first tick 4 cycles later with sec_en=1, min_en=1, both up=0; counters become 0:59.
REQ-037 Counters at 0:01 in RUN, tick -> sec_en pulse, state=3, alarm=1 on the same edge; then btn_start -> state=0, alarm=0.
REQ-038 RUN, btn_stop coincident with tick -> state=2, no sec_en; btn_start -> RUN and the pending tick fires; btn_stop twice from RUN -> IDLE with one cnt_clr pulse.
REQ-039 SCLR asserted mid-RUN while sec_en=1 -> all outputs 0 and state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/egg_timer_ctrl.sv
// rtl/egg_timer_ctrl.sv - countdown egg timer controller driving external min/sec up/down counters
module egg_timer_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       CLK,
    input  logic       SCLR,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_sec_inc,
    input  logic       btn_min_inc,
    input  logic [5:0] sec_q,
    input  logic [5:0] min_q,
    output logic       sec_en,
    output logic       sec_up,
    output logic       min_en,
    output logic       min_up,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       alarm
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_tick_cnt;
    logic            r_sec_en;
    logic            r_sec_up;
    logic            r_min_en;
    logic            r_min_up;
    logic            r_cnt_clr;
    logic            r_alarm;

    state_t          w_next_state;
    logic            w_tick;
    logic            w_zero;
    logic            w_sec_en;
    logic            w_sec_up;
    logic            w_min_en;
    logic            w_min_up;
    logic            w_cnt_clr;

    assign w_tick = (r_state == ST_RUN) && (r_tick_cnt == CW'(TICK_DIV - 1));
    assign w_zero = (sec_q == 6'd0) && (min_q == 6'd0);

    always_comb begin
        w_next_state = r_state;
        w_sec_en     = 1'b0;
        w_sec_up     = r_sec_up;
        w_min_en     = 1'b0;
        w_min_up     = r_min_up;
        w_cnt_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_stop) begin
                    w_cnt_clr = 1'b1;
                end else begin
                    if (btn_start && !w_zero)
                        w_next_state = ST_RUN;
                    if (btn_sec_inc) begin
                        w_sec_en = 1'b1;
                        w_sec_up = 1'b1;
                    end
                    if (btn_min_inc) begin
                        w_min_en = 1'b1;
                        w_min_up = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Zero check precedes tick so a stale 0:00 never borrows into 59:59
                if (btn_stop) begin
                    w_next_state = ST_PAUSE;
                end else if (w_zero) begin
                    w_next_state = ST_ALARM;
                end else if (w_tick) begin
                    w_sec_en = 1'b1;
                    w_sec_up = 1'b0;
                    if (sec_q == 6'd0) begin
                        w_min_en = 1'b1;
                        w_min_up = 1'b0;
                    end
                    if (min_q == 6'd0 && sec_q == 6'd1)
                        w_next_state = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (btn_stop) begin
                    w_next_state = ST_IDLE;
                    w_cnt_clr    = 1'b1;
                end else if (btn_start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn_start || btn_stop)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            r_state   <= ST_IDLE;
            r_sec_en  <= 1'b0;
            r_sec_up  <= 1'b0;
            r_min_en  <= 1'b0;
            r_min_up  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_sec_en  <= w_sec_en;
            r_sec_up  <= w_sec_up;
            r_min_en  <= w_min_en;
            r_min_up  <= w_min_up;
            r_cnt_clr <= w_cnt_clr;
            r_alarm   <= (w_next_state == ST_ALARM);
        end
    end

    // Stop in RUN freezes the divider so the interrupted tick fires right after resume
    always_ff @(posedge CLK or posedge SCLR) begin
        if (SCLR) begin
            r_tick_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!btn_stop)
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
                end
                ST_PAUSE: r_tick_cnt <= r_tick_cnt;
                default:  r_tick_cnt <= '0;
            endcase
        end
    end

    assign sec_en  = r_sec_en;
    assign sec_up  = r_sec_up;
    assign min_en  = r_min_en;
    assign min_up  = r_min_up;
    assign cnt_clr = r_cnt_clr;
    assign state   = r_state;
    assign alarm   = r_alarm;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb/tb_egg_timer_ctrl.sv - directed self-checking bench for egg_timer_ctrl with modelled min/sec counters
module tb_egg_timer_ctrl;

    logic       CLK = 1'b0;
    logic       SCLR = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_sec_inc = 1'b0;
    logic       btn_min_inc = 1'b0;
    logic [5:0] sec_q;
    logic [5:0] min_q;
    logic       sec_en, sec_up, min_en, min_up, cnt_clr, alarm;
    logic [1:0] state;

    logic       ld = 1'b0;
    logic [5:0] ld_sec = 6'd0;
    logic [5:0] ld_min = 6'd0;
    logic [5:0] sec_cnt = 6'd0;
    logic [5:0] min_cnt = 6'd0;

    int n_checks = 0;
    int n_fail   = 0;

    egg_timer_ctrl #(.TICK_DIV(4)) dut (
        .CLK        (CLK),
        .SCLR       (SCLR),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_sec_inc(btn_sec_inc),
        .btn_min_inc(btn_min_inc),
        .sec_q      (sec_q),
        .min_q      (min_q),
        .sec_en     (sec_en),
        .sec_up     (sec_up),
        .min_en     (min_en),
        .min_up     (min_up),
        .cnt_clr    (cnt_clr),
        .state      (state),
        .alarm      (alarm)
    );

    always #5 CLK = ~CLK;

    // External wrap-around counters as the timer sees them
    always @(posedge CLK) begin
        if (ld) begin
            sec_cnt <= ld_sec;
            min_cnt <= ld_min;
        end else if (cnt_clr) begin
            sec_cnt <= 6'd0;
            min_cnt <= 6'd0;
        end else begin
            if (sec_en)
                sec_cnt <= sec_up ? ((sec_cnt == 6'd59) ? 6'd0 : sec_cnt + 6'd1)
                                  : ((sec_cnt == 6'd0) ? 6'd59 : sec_cnt - 6'd1);
            if (min_en)
                min_cnt <= min_up ? ((min_cnt == 6'd59) ? 6'd0 : min_cnt + 6'd1)
                                  : ((min_cnt == 6'd0) ? 6'd59 : min_cnt - 6'd1);
        end
    end

    assign sec_q = sec_cnt;
    assign min_q = min_cnt;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int m, input int s);
        ld_min = 6'(m);
        ld_sec = 6'(s);
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    initial begin
        step();
        check("rst_state", int'(state), 0);
        check("rst_outs", int'({sec_en, sec_up, min_en, min_up, cnt_clr, alarm}), 0);
        SCLR = 1'b0;
        step();

        // Start at 0:00 is ignored
        load(0, 0);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        check("zero_start_state", int'(state), 0);
        check("zero_start_en", int'({sec_en, min_en}), 0);

        // Simultaneous increments
        btn_sec_inc = 1'b1; btn_min_inc = 1'b1; step();
        btn_sec_inc = 1'b0; btn_min_inc = 1'b0;
        check("inc_en", int'({sec_en, min_en}), 3);
        check("inc_up", int'({sec_up, min_up}), 3);
        step();
        check("inc_en_1cyc", int'({sec_en, min_en}), 0);
        check("inc_up_hold", int'({sec_up, min_up}), 3);
        check("inc_cnt", int'({min_cnt, sec_cnt}), (1 << 6) | 1);

        // Stop in IDLE clears
        btn_stop = 1'b1; step(); btn_stop = 1'b0;
        check("idle_clr", int'(cnt_clr), 1);
        check("idle_clr_state", int'(state), 0);
        step();
        check("idle_clr_1cyc", int'(cnt_clr), 0);
        check("idle_clr_cnt", int'({min_cnt, sec_cnt}), 0);

        // 1:00 start, borrow on first tick
        load(1, 0);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        check("run_state", int'(state), 1);
        btn_sec_inc = 1'b1; step(); btn_sec_inc = 1'b0;
        check("run_inc_ignored", int'(sec_en), 0);
        step(); step();
        check("pre_tick", int'({sec_en, min_en}), 0);
        step();
        check("tick_en", int'({sec_en, min_en}), 3);
        check("tick_dir", int'({sec_up, min_up}), 0);
        step();
        check("borrow_cnt", int'({min_cnt, sec_cnt}), 59);
        check("borrow_run", int'(state), 1);

        // 0:01 tick enters ALARM on the same edge
        load(0, 1);
        step();
        check("alarm_pre", int'(state), 1);
        step();
        check("alarm_sec_en", int'(sec_en), 1);
        check("alarm_state", int'(state), 3);
        check("alarm_flag", int'(alarm), 1);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        check("alarm_ack_state", int'(state), 0);
        check("alarm_ack_flag", int'(alarm), 0);

        // Stop coincident with tick, resume, stop twice
        load(0, 10);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        step(); step(); step();
        btn_stop = 1'b1; step(); btn_stop = 1'b0;
        check("pause_state", int'(state), 2);
        check("pause_no_dec", int'(sec_en), 0);
        step(); step();
        check("pause_hold", int'({sec_en, sec_cnt}), 10);
        btn_start = 1'b1; btn_stop = 1'b1; step(); btn_start = 1'b0; btn_stop = 1'b0;
        check("stop_priority", int'(state), 0);
        check("stop_priority_clr", int'(cnt_clr), 1);

        load(0, 10);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        step(); step(); step();
        btn_stop = 1'b1; step(); btn_stop = 1'b0;
        check("pause2_state", int'(state), 2);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        check("resume_state", int'(state), 1);
        step();
        check("resume_tick", int'(sec_en), 1);
        btn_stop = 1'b1; step();
        check("stop1_state", int'(state), 2);
        check("stop1_no_clr", int'(cnt_clr), 0);
        check("resume_dec_cnt", int'(sec_cnt), 9);
        step(); btn_stop = 1'b0;
        check("stop2_state", int'(state), 0);
        check("stop2_clr", int'(cnt_clr), 1);
        step();
        check("stop2_clr_1cyc", int'(cnt_clr), 0);

        // Asynchronous reset while sec_en is high
        load(1, 0);
        btn_start = 1'b1; step(); btn_start = 1'b0;
        step(); step(); step(); step();
        check("pre_rst_sec_en", int'(sec_en), 1);
        #2 SCLR = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_outs", int'({sec_en, sec_up, min_en, min_up, cnt_clr, alarm}), 0);
        step();
        SCLR = 1'b0;
        step();
        check("post_rst_state", int'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
